// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S / left-justified transmitter.
//   MODE_I2S / MODE_LJ : values of the mode input
//   MAX_SLOT           : widest channel slot pack_slot() can build
//   pack_slot()        : places a right-aligned sample at the top of a
//                        slot-bit field with zero padding below it
package i2s_pkg;

  localparam logic MODE_I2S = 1'b0;  // one bit of data delay after ws edge
  localparam logic MODE_LJ  = 1'b1;  // data MSB coincides with ws edge

  localparam int unsigned MAX_SLOT = 64;

  // Returns the sample left-justified inside the low `slot` bits of the
  // result: bits [slot-1 -: width] hold the sample, the rest are zero.
  // Bits above `slot` are always zero. Requires width <= slot <= MAX_SLOT.
  function automatic logic [MAX_SLOT-1:0] pack_slot(
    input logic [31:0] sample,
    input int unsigned width,
    input int unsigned slot
  );
    logic [MAX_SLOT-1:0] v;
    v = {{(MAX_SLOT-32){1'b0}}, sample};
    return v << (slot - width);
  endfunction

endpackage

// File: rtl/i2s_fifo.sv
// i2s_fifo: single-clock FIFO holding stereo sample pairs.
//   clock, reset : system clock, synchronous active-high reset
//   push, wdata  : write strobe and data (ignored while full)
//   pop,  rdata  : read strobe (ignored while empty); rdata shows the head
//   full, empty  : decoded from the registered occupancy count
module i2s_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its inputs from before the edge.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the count alone
  // decides which entries are valid, so stale contents are never read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S / left-justified serial audio transmitter.
//   clock, reset : system clock, synchronous active-high reset
//   mode         : 0 = I2S (one bit data delay), 1 = left-justified;
//                  takes effect at the start of the next frame
//   in_valid/in_ready, in_l, in_r : sample pair handshake into the FIFO
//   i2s          : {sd, ws, sck} serial outputs
//   underrun     : one-cycle pulse when a frame load finds the FIFO empty
// SCK period is 2*DIV clocks; each channel slot lasts SLOT bit periods with
// the sample MSB first, zero padded to the end of the slot.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLOT  = 32,
  parameter int unsigned DIV   = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_l,
  input  logic [WIDTH-1:0] in_r,
  output logic [2:0]       i2s,
  output logic             underrun
);

  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BCW = $clog2(2 * SLOT);

  logic [DCW-1:0]       dc;
  logic                 sck;
  logic [BCW-1:0]       bc;
  logic [2*SLOT-1:0]    sr;
  logic                 mode_q;

  logic                 tick;
  logic                 bit_edge;
  logic [BCW-1:0]       bc_next;
  logic                 mode_eff;
  logic                 load;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [2*WIDTH-1:0]   fifo_rdata;
  logic [MAX_SLOT-1:0]  pk_l;
  logic [MAX_SLOT-1:0]  pk_r;
  logic [2*SLOT-1:0]    load_word;
  logic                 unused_pack;

  i2s_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .wdata ({in_l, in_r}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

  assign pk_l        = pack_slot(32'(fifo_rdata[2*WIDTH-1:WIDTH]), WIDTH, SLOT);
  assign pk_r        = pack_slot(32'(fifo_rdata[WIDTH-1:0]), WIDTH, SLOT);
  assign load_word   = {pk_l[SLOT-1:0], pk_r[SLOT-1:0]};
  // Only the low SLOT bits of each packed word are meaningful.
  assign unused_pack = ^{pk_l, pk_r};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    tick     = 1'b0;
    bit_edge = 1'b0;
    bc_next  = bc + 1'b1;
    mode_eff = mode_q;
    load     = 1'b0;

    tick     = (dc == DCW'(DIV - 1));
    bit_edge = tick && sck;  // sck about to fall: bit boundary

    if (bc == BCW'(2 * SLOT - 1)) bc_next = '0;

    // The frame-start boundary is also where mode is latched, so the load
    // decision on that boundary must already use the incoming mode.
    if (bc_next == '0) mode_eff = mode;

    load = bit_edge &&
           (((mode_eff == MODE_I2S) && (bc_next == BCW'(1))) ||
            ((mode_eff == MODE_LJ)  && (bc_next == '0)));
  end

  assign fifo_pop = load && !fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      dc       <= '0;
      sck      <= 1'b0;
      bc       <= '0;
      sr       <= '0;
      mode_q   <= mode;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      dc       <= tick ? '0 : dc + 1'b1;
      if (tick) sck <= !sck;

      if (bit_edge) begin
        bc <= bc_next;
        if (bc_next == '0) mode_q <= mode;
        if (load) begin
          sr       <= fifo_empty ? '0 : load_word;
          underrun <= fifo_empty;
        end else begin
          sr <= sr << 1;
        end
      end
    end
  end

  // sd and ws both change on the edge where sck falls.
  assign i2s = {sr[2*SLOT-1], (bc >= BCW'(SLOT)), sck};

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with two configurations:
//   dut_a : WIDTH=16 SLOT=16 DIV=2 DEPTH=4
//   dut_b : WIDTH=24 SLOT=32 DIV=4 DEPTH=4
// The bench tracks the bit counter itself by watching sck fall and
// compares captured sd/ws frames against hand-derived bit patterns.
module tb_i2s_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- dut_a ----------------
  logic        a_reset, a_mode, a_valid, a_ready, a_underrun;
  logic [15:0] a_l, a_r;
  logic [2:0]  a_i2s;

  i2s_tx #(.WIDTH(16), .SLOT(16), .DIV(2), .DEPTH(4)) dut_a (
    .clock    (clock),
    .reset    (a_reset),
    .mode     (a_mode),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .in_l     (a_l),
    .in_r     (a_r),
    .i2s      (a_i2s),
    .underrun (a_underrun)
  );

  // ---------------- dut_b ----------------
  logic        b_reset, b_mode, b_valid, b_ready, b_underrun;
  logic [23:0] b_l, b_r;
  logic [2:0]  b_i2s;

  i2s_tx #(.WIDTH(24), .SLOT(32), .DIV(4), .DEPTH(4)) dut_b (
    .clock    (clock),
    .reset    (b_reset),
    .mode     (b_mode),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .in_l     (b_l),
    .in_r     (b_r),
    .i2s      (b_i2s),
    .underrun (b_underrun)
  );

  // Bench-side bit tracking for dut_a
  int   a_bc;
  logic a_prev;
  logic a_fell;
  int   a_urun_cnt;
  int   a_urun_bc;

  // Bench-side bit tracking for dut_b
  int   b_bc;
  logic b_prev;
  logic b_fell;
  int   b_urun_cnt;
  int   b_cyc;
  int   b_rise_cyc;
  int   b_period;

  // ---------------- expected patterns ----------------
  // I2S, 16-bit in 16-bit slots, indexed by bit counter value.
  function automatic logic [31:0] exp_i2s16(input logic [15:0] l, input logic [15:0] r);
    logic [31:0] v;
    v    = '0;
    v[0] = r[0];
    for (int b = 1; b <= 16; b++) v[b] = l[16-b];
    for (int b = 17; b <= 31; b++) v[b] = r[32-b];
    return v;
  endfunction

  function automatic logic [31:0] exp_lj16(input logic [15:0] l, input logic [15:0] r);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) v[b] = l[15-b];
    for (int b = 16; b < 32; b++) v[b] = r[31-b];
    return v;
  endfunction

  // I2S, 24-bit samples in 32-bit slots.
  function automatic logic [63:0] exp_i2s24(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    v = '0;
    for (int b = 1; b <= 24; b++) v[b] = l[24-b];
    for (int b = 33; b <= 56; b++) v[b] = r[56-b];
    return v;
  endfunction

  // ---------------- dut_a helpers ----------------
  task automatic a_tick();
    @(negedge clock);
    a_fell = a_prev && !a_i2s[0];
    a_prev = a_i2s[0];
    if (a_reset) begin
      a_bc   = 0;
      a_prev = 1'b0;
      a_fell = 1'b0;
    end else if (a_fell) begin
      a_bc = (a_bc + 1) % 32;
    end
    if (a_underrun) begin
      a_urun_cnt++;
      a_urun_bc = a_bc;
    end
  endtask

  task automatic a_next_bit();
    int n;
    n = 0;
    do begin
      a_tick();
      n++;
    end while (!a_fell && n < 16);
    if (!a_fell) begin
      checks++;
      errors++;
      $display("FAIL a_bit_timeout: no sck fall within %0d clocks", n);
    end
  endtask

  task automatic a_do_reset();
    a_reset = 1'b1;
    repeat (3) a_tick();
    a_reset = 1'b0;
  endtask

  task automatic a_push(input logic [15:0] l, input logic [15:0] r);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_push_ready: in_ready=%b required 1", a_ready);
    end
    a_valid = 1'b1;
    a_l     = l;
    a_r     = r;
    a_tick();
    a_valid = 1'b0;
  endtask

  // Records the current bit and the next 31, indexed by bit counter.
  task automatic a_capture(output logic [31:0] sdv, output logic [31:0] wsv,
                           input int toggle_bc);
    sdv = '0;
    wsv = '0;
    sdv[a_bc] = a_i2s[2];
    wsv[a_bc] = a_i2s[1];
    for (int i = 1; i < 32; i++) begin
      a_next_bit();
      sdv[a_bc] = a_i2s[2];
      wsv[a_bc] = a_i2s[1];
      if (a_bc == toggle_bc) a_mode = ~a_mode;
    end
  endtask

  // ---------------- dut_b helpers ----------------
  task automatic b_tick();
    @(negedge clock);
    b_cyc++;
    if (!b_prev && b_i2s[0]) begin
      b_period   = b_cyc - b_rise_cyc;
      b_rise_cyc = b_cyc;
    end
    b_fell = b_prev && !b_i2s[0];
    b_prev = b_i2s[0];
    if (b_reset) begin
      b_bc   = 0;
      b_prev = 1'b0;
      b_fell = 1'b0;
    end else if (b_fell) begin
      b_bc = (b_bc + 1) % 64;
    end
    if (b_underrun) b_urun_cnt++;
  endtask

  task automatic b_next_bit();
    int n;
    n = 0;
    do begin
      b_tick();
      n++;
    end while (!b_fell && n < 32);
    if (!b_fell) begin
      checks++;
      errors++;
      $display("FAIL b_bit_timeout: no sck fall within %0d clocks", n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_reset = 1'b1;
    a_tick();
    a_tick();
    checks++;
    if (a_i2s !== 3'b000) begin
      errors++;
      $display("FAIL reset_i2s: i2s=%b required 000", a_i2s);
    end
    checks++;
    if (a_underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_underrun: underrun=%b required 0", a_underrun);
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", a_ready);
    end
    a_reset = 1'b0;
    a_tick();
    checks++;
    if (a_ready !== 1'b1 || a_i2s !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b i2s=%b required 1 000", a_ready, a_i2s);
    end
  endtask

  task automatic test_i2s_frame();
    logic [31:0] sdv, wsv;
    a_mode = 1'b0;
    a_do_reset();
    a_urun_cnt = 0;
    a_push(16'h8001, 16'h7FFE);
    a_next_bit();
    a_capture(sdv, wsv, -1);
    checks++;
    if (sdv !== exp_i2s16(16'h8001, 16'h7FFE)) begin
      errors++;
      $display("FAIL i2s_sd: got %h required %h", sdv, exp_i2s16(16'h8001, 16'h7FFE));
    end
    checks++;
    if (wsv !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL i2s_ws: got %h required ffff0000", wsv);
    end
    checks++;
    if (a_urun_cnt != 0) begin
      errors++;
      $display("FAIL i2s_no_underrun: pulses=%0d required 0", a_urun_cnt);
    end
    // Next frame finds the FIFO empty.
    a_next_bit();
    checks++;
    if (a_underrun !== 1'b1 || a_bc != 1) begin
      errors++;
      $display("FAIL i2s_empty_load: underrun=%b bc=%0d required 1 at bc 1", a_underrun, a_bc);
    end
  endtask

  task automatic test_lj_mode();
    logic [31:0] sdv, wsv;
    int n;
    a_mode = 1'b1;
    a_do_reset();
    a_urun_cnt = 0;
    a_push(16'h8001, 16'h7FFE);
    a_push(16'hC003, 16'h0005);
    n = 0;
    do begin
      a_next_bit();
      n++;
    end while (a_bc != 0 && n < 40);
    // Toggle to I2S at bc 5: this frame must stay left-justified.
    a_capture(sdv, wsv, 5);
    checks++;
    if (sdv !== exp_lj16(16'h8001, 16'h7FFE)) begin
      errors++;
      $display("FAIL lj_sd: got %h required %h", sdv, exp_lj16(16'h8001, 16'h7FFE));
    end
    checks++;
    if (wsv !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL lj_ws: got %h required ffff0000", wsv);
    end
    // Following frame is I2S: bc 0 carries the exhausted shift register.
    a_next_bit();
    a_capture(sdv, wsv, -1);
    checks++;
    if (sdv !== (exp_i2s16(16'hC003, 16'h0005) & ~32'h1)) begin
      errors++;
      $display("FAIL lj_to_i2s_sd: got %h required %h", sdv,
               exp_i2s16(16'hC003, 16'h0005) & ~32'h1);
    end
    checks++;
    if (a_urun_cnt != 0) begin
      errors++;
      $display("FAIL lj_no_underrun: pulses=%0d required 0", a_urun_cnt);
    end
  endtask

  task automatic test_underrun();
    logic sd_or;
    a_mode = 1'b0;
    a_do_reset();
    a_urun_cnt = 0;
    a_urun_bc  = -1;
    sd_or      = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a_next_bit();
      sd_or = sd_or | a_i2s[2];
    end
    checks++;
    if (a_urun_cnt != 2 || a_urun_bc != 1) begin
      errors++;
      $display("FAIL underrun_pulses: count=%0d last_bc=%0d required 2 at bc 1",
               a_urun_cnt, a_urun_bc);
    end
    checks++;
    if (sd_or !== 1'b0) begin
      errors++;
      $display("FAIL underrun_sd: sd seen=%b required 0", sd_or);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bl [6];
    logic [15:0] br [6];
    int k;
    int first_low;
    bl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    br = '{16'hA0A1, 16'hB0B2, 16'hC0C3, 16'hD0D4, 16'hE0E5, 16'hF0F6};
    a_mode = 1'b0;
    a_do_reset();
    a_next_bit();  // first load already passed, FIFO was empty
    a_urun_cnt = 0;
    k          = 0;
    first_low  = -1;
    fork
      begin
        int cyc;
        logic acc;
        cyc = 0;
        while (k < 6 && cyc < 1500) begin
          a_valid = 1'b1;
          a_l     = bl[k];
          a_r     = br[k];
          acc     = a_ready;
          if (!a_ready && first_low < 0) first_low = k;
          @(negedge clock);
          if (acc) k++;
          cyc++;
        end
        a_valid = 1'b0;
      end
      begin
        logic [31:0] sdv, wsv;
        int n;
        for (int f = 0; f < 6; f++) begin
          a_next_bit();
          n = 0;
          while (a_bc != 1 && n < 40) begin
            a_next_bit();
            n++;
          end
          a_capture(sdv, wsv, -1);
          checks++;
          if (sdv !== exp_i2s16(bl[f], br[f])) begin
            errors++;
            $display("FAIL b2b_frame%0d: got %h required %h", f, sdv, exp_i2s16(bl[f], br[f]));
          end
        end
      end
    join
    checks++;
    if (first_low != 4) begin
      errors++;
      $display("FAIL b2b_ready_low: ready fell after %0d accepts required 4", first_low);
    end
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL b2b_accepted: accepted=%0d required 6", k);
    end
    checks++;
    if (a_urun_cnt != 0) begin
      errors++;
      $display("FAIL b2b_underrun: pulses=%0d required 0", a_urun_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] sdv, wsv;
    int n;
    a_mode = 1'b0;
    a_do_reset();
    a_push(16'h1234, 16'h5678);
    a_push(16'h9ABC, 16'hDEF0);
    n = 0;
    do begin
      a_next_bit();
      n++;
    end while (a_bc != 5 && n < 40);
    a_reset    = 1'b1;
    a_urun_cnt = 0;
    a_tick();
    checks++;
    if (a_i2s !== 3'b000 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: i2s=%b in_ready=%b required 000 1", a_i2s, a_ready);
    end
    repeat (3) a_tick();
    checks++;
    if (a_urun_cnt != 0) begin
      errors++;
      $display("FAIL midreset_underrun: pulses=%0d required 0", a_urun_cnt);
    end
    a_reset = 1'b0;
    a_tick();
    checks++;
    if (a_ready !== 1'b1 || a_i2s !== 3'b000) begin
      errors++;
      $display("FAIL midreset_release: in_ready=%b i2s=%b required 1 000", a_ready, a_i2s);
    end
    // FIFO was flushed: first load underruns and the frame is silent.
    a_next_bit();
    checks++;
    if (a_underrun !== 1'b1) begin
      errors++;
      $display("FAIL midreset_flushed: underrun=%b required 1", a_underrun);
    end
    a_capture(sdv, wsv, -1);
    checks++;
    if (sdv !== 32'h0) begin
      errors++;
      $display("FAIL midreset_sd: got %h required 00000000", sdv);
    end
  endtask

  task automatic test_width24();
    logic [63:0] sdv, wsv;
    b_mode  = 1'b0;
    b_reset = 1'b1;
    repeat (3) b_tick();
    b_reset    = 1'b0;
    b_urun_cnt = 0;
    b_valid    = 1'b1;
    b_l        = 24'hA5A5A5;
    b_r        = 24'h3C3C3C;
    b_tick();
    b_valid = 1'b0;
    b_next_bit();
    sdv = '0;
    wsv = '0;
    sdv[b_bc] = b_i2s[2];
    wsv[b_bc] = b_i2s[1];
    for (int i = 1; i < 64; i++) begin
      b_next_bit();
      sdv[b_bc] = b_i2s[2];
      wsv[b_bc] = b_i2s[1];
    end
    checks++;
    if (sdv !== exp_i2s24(24'hA5A5A5, 24'h3C3C3C)) begin
      errors++;
      $display("FAIL w24_sd: got %h required %h", sdv, exp_i2s24(24'hA5A5A5, 24'h3C3C3C));
    end
    checks++;
    if (wsv !== 64'hFFFF_FFFF_0000_0000) begin
      errors++;
      $display("FAIL w24_ws: got %h required ffffffff00000000", wsv);
    end
    checks++;
    if (b_period != 8) begin
      errors++;
      $display("FAIL w24_sck_period: got %0d clocks required 8", b_period);
    end
    checks++;
    if (b_urun_cnt != 0) begin
      errors++;
      $display("FAIL w24_underrun: pulses=%0d required 0", b_urun_cnt);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_mode = 1'b0; a_valid = 1'b0; a_l = '0; a_r = '0;
    b_reset = 1'b1; b_mode = 1'b0; b_valid = 1'b0; b_l = '0; b_r = '0;
    a_bc = 0; a_prev = 1'b0; a_fell = 1'b0; a_urun_cnt = 0; a_urun_bc = -1;
    b_bc = 0; b_prev = 1'b0; b_fell = 1'b0; b_urun_cnt = 0;
    b_cyc = 0; b_rise_cyc = 0; b_period = 0;

    test_reset();
    test_i2s_frame();
    test_lj_mode();
    test_underrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_width24();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
